// File: rtl/slave_fifo_bridge_pkg.sv
// slave_fifo_bridge_pkg: port addresses, STATUS/CTRL bit indices and FSM encoding for the slave FIFO bridge
package slave_fifo_bridge_pkg;
  localparam logic [7:0] DATA_PORT_DEF   = 8'h00;
  localparam logic [7:0] STATUS_PORT_DEF = 8'h01;
  localparam logic [7:0] CTRL_PORT_DEF   = 8'h02;
  localparam int ST_HEAD_VALID = 0;
  localparam int ST_EMPTY      = 1;
  localparam int ST_FULL       = 2;
  localparam int ST_THRESH     = 3;
  localparam int ST_UNF        = 4;
  localparam int ST_OVF        = 5;
  localparam int CTRL_IRQ_EN = 0;
  localparam int CTRL_CLR    = 1;
  localparam int CTRL_FLUSH  = 2;
  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2} state_e;
endpackage

// File: rtl/slave_fifo_bridge.sv
// slave_fifo_bridge: prefetches the FIFO head and maps DATA/STATUS/CTRL onto KCPSM6 slave ports
module slave_fifo_bridge
  import slave_fifo_bridge_pkg::*;
#(
  parameter logic [7:0] DATA_PORT   = DATA_PORT_DEF,
  parameter logic [7:0] STATUS_PORT = STATUS_PORT_DEF,
  parameter logic [7:0] CTRL_PORT   = CTRL_PORT_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [7:0] port_id,
  input  logic       read_strobe,
  input  logic       write_strobe,
  input  logic [7:0] out_port,
  output logic [7:0] in_port,
  output logic       interrupt,
  input  logic       interrupt_ack,
  output logic       fifo_rd,
  input  logic [7:0] fifo_dout,
  input  logic       fifo_empty,
  input  logic       fifo_full,
  input  logic       fifo_threshold,
  input  logic       fifo_overflow
);
  state_e     state_q;
  logic [7:0] head_q;
  logic       head_valid_q;
  logic       irq_en_q;
  logic       unf_q;
  logic       ovf_q;
  logic       irq_q;
  logic [7:0] in_port_q;
  logic [7:0] in_port_d;
  logic [7:0] status;
  logic       pop;
  logic       ctrl_wr;
  logic       flush;
  logic       clr;
  logic       enter_hold;
  // Port decode, pop request and the next in_port byte
  always_comb begin
    pop        = read_strobe && port_id == DATA_PORT;
    ctrl_wr    = write_strobe && port_id == CTRL_PORT;
    flush      = ctrl_wr && out_port[CTRL_FLUSH];
    clr        = ctrl_wr && out_port[CTRL_CLR];
    enter_hold = state_q == FETCH && !flush;
    fifo_rd    = !reset && !flush && !fifo_empty && (state_q == IDLE || (state_q == HOLD && pop));
    status     = {2'b00, ovf_q, unf_q, fifo_threshold, fifo_full, fifo_empty, head_valid_q};
    in_port_d  = port_id == DATA_PORT   ? (head_valid_q ? head_q : 8'h00) :
                 port_id == STATUS_PORT ? status : 8'h00;
  end
  // in_port is re-registered every cycle from the current port_id
  always_ff @(posedge clock) begin
    in_port_q <= reset ? 8'h00 : in_port_d;
  end
  // Prefetch FSM: at most one outstanding pop; a flush abandons any in-flight byte
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      head_q       <= 8'h00;
      head_valid_q <= 1'b0;
    end else if (flush) begin
      state_q      <= IDLE;
      head_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE:    state_q <= fifo_empty ? IDLE : FETCH;
        FETCH: begin
          head_q       <= fifo_dout;
          head_valid_q <= 1'b1;
          state_q      <= HOLD;
        end
        HOLD: if (pop) begin
          head_valid_q <= 1'b0;
          state_q      <= fifo_empty ? IDLE : FETCH;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  // Interrupt and sticky flags: a set always beats a same-cycle clear or ack
  always_ff @(posedge clock) begin
    if (reset) begin
      irq_en_q <= 1'b1;
      irq_q    <= 1'b0;
      unf_q    <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (ctrl_wr) irq_en_q <= out_port[CTRL_IRQ_EN];
      irq_q <= (enter_hold && irq_en_q) || (irq_q && !interrupt_ack);
      unf_q <= (pop && !head_valid_q) || (unf_q && !clr);
      ovf_q <= fifo_overflow || (ovf_q && !clr);
    end
  end
  assign in_port   = in_port_q;
  assign interrupt = irq_q;
endmodule

// File: tb/tb_slave_fifo_bridge.sv
// tb_slave_fifo_bridge: directed scenarios plus randomized traffic against a byte-queue reference model
module tb_slave_fifo_bridge;
  localparam logic [7:0] DP = 8'h00;
  localparam logic [7:0] SP = 8'h01;
  localparam logic [7:0] CP = 8'h02;
  localparam logic [7:0] NP = 8'h80;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] port_id = NP;
  logic       read_strobe = 1'b0;
  logic       write_strobe = 1'b0;
  logic [7:0] out_port = 8'h00;
  logic [7:0] in_port;
  logic       interrupt;
  logic       interrupt_ack = 1'b0;
  logic       fifo_rd;
  logic [7:0] fifo_dout = 8'h00;
  logic       fifo_empty;
  logic       fifo_full;
  logic       fifo_threshold;
  logic       fifo_overflow = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  // Environment FIFO: tasks write mem/wr_idx, the clocked process owns rd_idx
  logic [7:0] mem [256];
  int wr_idx = 0;
  int rd_idx = 0;
  int rd_count = 0;
  int fifo_err = 0;

  always #5 clock = ~clock;

  assign fifo_empty     = (wr_idx == rd_idx);
  assign fifo_full      = (wr_idx - rd_idx) >= 8;
  assign fifo_threshold = (wr_idx - rd_idx) >= 4;

  always @(posedge clock) begin
    if (fifo_rd) begin
      rd_count <= rd_count + 1;
      if (wr_idx == rd_idx) fifo_err <= fifo_err + 1;
      else begin
        fifo_dout <= mem[rd_idx % 256];
        rd_idx    <= rd_idx + 1;
      end
    end
  end

  slave_fifo_bridge dut (
    .clock(clock), .reset(reset), .port_id(port_id), .read_strobe(read_strobe),
    .write_strobe(write_strobe), .out_port(out_port), .in_port(in_port),
    .interrupt(interrupt), .interrupt_ack(interrupt_ack), .fifo_rd(fifo_rd),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_full(fifo_full),
    .fifo_threshold(fifo_threshold), .fifo_overflow(fifo_overflow)
  );

  task automatic settle(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push_byte(input logic [7:0] b);
    @(negedge clock);
    mem[wr_idx % 256] = b;
    wr_idx = wr_idx + 1;
  endtask

  task automatic rd_port(input logic [7:0] id, output logic [7:0] v);
    @(negedge clock);
    port_id = id;
    read_strobe = 1'b0;
    @(negedge clock);
    read_strobe = 1'b1;
    v = in_port;
    @(negedge clock);
    read_strobe = 1'b0;
    port_id = NP;
  endtask

  task automatic wr_ctrl(input logic [7:0] v);
    @(negedge clock);
    port_id = CP;
    out_port = v;
    write_strobe = 1'b1;
    @(negedge clock);
    write_strobe = 1'b0;
    port_id = NP;
  endtask

  task automatic pulse_ack;
    @(negedge clock);
    interrupt_ack = 1'b1;
    @(negedge clock);
    interrupt_ack = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] v;
    reset = 1'b1;
    settle(3);
    n_cmp++; if (in_port !== 8'h00) begin n_bad++; $display("FAIL reset_in_port got %h want 00", in_port); end
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", interrupt); end
    n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL reset_fifo_rd got %b want 0", fifo_rd); end
    reset = 1'b0;
    rd_port(SP, v);
    n_cmp++; if (v !== 8'h02) begin n_bad++; $display("FAIL reset_status got %h want 02", v); end
    settle(3);
    n_cmp++; if (rd_count !== 0) begin n_bad++; $display("FAIL reset_no_pop got %0d want 0", rd_count); end
  endtask

  task automatic test_single;
    logic [7:0] v;
    int c0 = rd_count;
    push_byte(8'hA5);
    #1;
    n_cmp++; if (fifo_rd !== 1'b1) begin n_bad++; $display("FAIL single_rd_pulse got %b want 1", fifo_rd); end
    @(negedge clock);
    n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL single_rd_once got %b want 0", fifo_rd); end
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL single_irq_early got %b want 0", interrupt); end
    @(negedge clock);
    n_cmp++; if (interrupt !== 1'b1) begin n_bad++; $display("FAIL single_irq got %b want 1", interrupt); end
    rd_port(SP, v);
    n_cmp++; if (v !== 8'h03) begin n_bad++; $display("FAIL single_status_hv got %h want 03", v); end
    rd_port(DP, v);
    n_cmp++; if (v !== 8'hA5) begin n_bad++; $display("FAIL single_data got %h want a5", v); end
    settle(2);
    rd_port(SP, v);
    n_cmp++; if (v !== 8'h02) begin n_bad++; $display("FAIL single_status_idle got %h want 02", v); end
    n_cmp++; if (rd_count - c0 !== 1) begin n_bad++; $display("FAIL single_pop_count got %0d want 1", rd_count - c0); end
  endtask

  task automatic test_back_to_back;
    logic [7:0] v;
    logic [7:0] exp [3];
    int c0 = rd_count;
    exp = '{8'h11, 8'h22, 8'h33};
    for (int i = 0; i < 3; i++) push_byte(exp[i]);
    settle(3);
    for (int i = 0; i < 3; i++) begin
      rd_port(DP, v);
      n_cmp++; if (v !== exp[i]) begin n_bad++; $display("FAIL b2b_data%0d got %h want %h", i, v, exp[i]); end
    end
    settle(3);
    n_cmp++; if (rd_count - c0 !== 3) begin n_bad++; $display("FAIL b2b_pop_count got %0d want 3", rd_count - c0); end
  endtask

  task automatic test_underflow;
    logic [7:0] v;
    rd_port(DP, v);
    n_cmp++; if (v !== 8'h00) begin n_bad++; $display("FAIL unf_data got %h want 00", v); end
    rd_port(SP, v);
    n_cmp++; if (v !== 8'h12) begin n_bad++; $display("FAIL unf_status got %h want 12", v); end
    wr_ctrl(8'h03);
    rd_port(SP, v);
    n_cmp++; if (v !== 8'h02) begin n_bad++; $display("FAIL unf_clear got %h want 02", v); end
    pulse_ack();
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL unf_ack got %b want 0", interrupt); end
    push_byte(8'h5A);
    settle(3);
    n_cmp++; if (interrupt !== 1'b1) begin n_bad++; $display("FAIL unf_irq_en_kept got %b want 1", interrupt); end
    rd_port(DP, v);
    n_cmp++; if (v !== 8'h5A) begin n_bad++; $display("FAIL unf_data2 got %h want 5a", v); end
  endtask

  task automatic test_irq_ack_race;
    logic [7:0] v;
    push_byte(8'h44);
    push_byte(8'h55);
    settle(3);
    @(negedge clock);
    port_id = DP;
    @(negedge clock);
    read_strobe = 1'b1;
    v = in_port;
    n_cmp++; if (v !== 8'h44) begin n_bad++; $display("FAIL race_data got %h want 44", v); end
    @(negedge clock);
    read_strobe = 1'b0;
    port_id = NP;
    interrupt_ack = 1'b1;
    @(negedge clock);
    interrupt_ack = 1'b0;
    n_cmp++; if (interrupt !== 1'b1) begin n_bad++; $display("FAIL race_set_wins got %b want 1", interrupt); end
    pulse_ack();
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL race_lone_ack got %b want 0", interrupt); end
    rd_port(DP, v);
    n_cmp++; if (v !== 8'h55) begin n_bad++; $display("FAIL race_data2 got %h want 55", v); end
    settle(3);
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL race_no_irq got %b want 0", interrupt); end
  endtask

  task automatic test_flush_reset;
    logic [7:0] v;
    int c0 = rd_count;
    push_byte(8'hC3);
    @(negedge clock);
    port_id = CP;
    out_port = 8'h05;
    write_strobe = 1'b1;
    @(negedge clock);
    write_strobe = 1'b0;
    port_id = NP;
    settle(2);
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL flush_irq got %b want 0", interrupt); end
    rd_port(SP, v);
    n_cmp++; if (v !== 8'h02) begin n_bad++; $display("FAIL flush_status got %h want 02", v); end
    n_cmp++; if (rd_count - c0 !== 1) begin n_bad++; $display("FAIL flush_pop_count got %0d want 1", rd_count - c0); end
    push_byte(8'h77);
    settle(3);
    @(negedge clock);
    port_id = SP;
    @(negedge clock);
    n_cmp++; if (in_port !== 8'h03) begin n_bad++; $display("FAIL hold_status got %h want 03", in_port); end
    reset = 1'b1;
    @(negedge clock);
    n_cmp++; if (in_port !== 8'h00) begin n_bad++; $display("FAIL midreset_in_port got %h want 00", in_port); end
    n_cmp++; if (interrupt !== 1'b0) begin n_bad++; $display("FAIL midreset_irq got %b want 0", interrupt); end
    n_cmp++; if (fifo_rd !== 1'b0) begin n_bad++; $display("FAIL midreset_fifo_rd got %b want 0", fifo_rd); end
    reset = 1'b0;
    port_id = NP;
    rd_port(SP, v);
    n_cmp++; if (v !== 8'h02) begin n_bad++; $display("FAIL midreset_status got %h want 02", v); end
    push_byte(8'h66);
    settle(3);
    n_cmp++; if (interrupt !== 1'b1) begin n_bad++; $display("FAIL midreset_irq_en got %b want 1", interrupt); end
    rd_port(DP, v);
    n_cmp++; if (v !== 8'h66) begin n_bad++; $display("FAIL midreset_data got %h want 66", v); end
  endtask

  task automatic test_random;
    logic [7:0] q [$];
    logic [7:0] v;
    logic [7:0] e;
    logic irq_en_m = 1'b1;
    logic irq_m = 1'b0;
    logic unf_m = 1'b0;
    logic ovf_m = 1'b0;
    int r;
    @(negedge clock);
    reset = 1'b1;
    settle(2);
    reset = 1'b0;
    for (int it = 0; it < 200; it++) begin
      case ($urandom_range(0, 5))
        0: if (q.size() <= 7) begin
          int n;
          bit was_empty;
          n = $urandom_range(1, 3);
          was_empty = q.size() == 0;
          for (int k = 0; k < n; k++) begin
            e = 8'($urandom);
            q.push_back(e);
            push_byte(e);
          end
          settle(3);
          if (was_empty && irq_en_m) irq_m = 1'b1;
        end
        1: begin
          rd_port(DP, v);
          if (q.size() > 0) e = q.pop_front();
          else begin
            e = 8'h00;
            unf_m = 1'b1;
          end
          n_cmp++; if (v !== e) begin n_bad++; $display("FAIL rnd_data it%0d got %h want %h", it, v, e); end
          settle(3);
          if (q.size() > 0 && irq_en_m) irq_m = 1'b1;
        end
        2: begin
          rd_port(SP, v);
          r = q.size() > 0 ? q.size() - 1 : 0;
          e = {2'b00, ovf_m, unf_m, r >= 4, r >= 8, r == 0, q.size() > 0};
          n_cmp++; if (v !== e) begin n_bad++; $display("FAIL rnd_status it%0d got %h want %h", it, v, e); end
        end
        3: begin
          @(negedge clock);
          fifo_overflow = 1'b1;
          @(negedge clock);
          fifo_overflow = 1'b0;
          ovf_m = 1'b1;
        end
        4: begin
          e = 8'($urandom_range(0, 3));
          wr_ctrl(e);
          irq_en_m = e[0];
          if (e[1]) begin
            unf_m = 1'b0;
            ovf_m = 1'b0;
          end
        end
        default: begin
          pulse_ack();
          irq_m = 1'b0;
        end
      endcase
      n_cmp++; if (interrupt !== irq_m) begin n_bad++; $display("FAIL rnd_irq it%0d got %b want %b", it, interrupt, irq_m); end
      r = q.size() > 0 ? q.size() - 1 : 0;
      n_cmp++; if (wr_idx - rd_idx !== r) begin n_bad++; $display("FAIL rnd_fifo_level it%0d got %0d want %0d", it, wr_idx - rd_idx, r); end
    end
    n_cmp++; if (fifo_err !== 0) begin n_bad++; $display("FAIL pop_while_empty got %0d want 0", fifo_err); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_underflow();
    test_irq_ack_race();
    test_flush_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
